// File: rtl/tdc_phase_meter.sv
// Phase/period meter: counts clk cycles from each ref rising edge to the next sig rising edge
// and between ref rising edges, then averages 2^AVG_LOG2 complete phase/period pairs.
module tdc_phase_meter #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ref_in,
    input  logic             sig_in,
    output logic [CNT_W-1:0] phase_avg,
    output logic [CNT_W-1:0] period_avg,
    output logic             avg_valid,
    output logic [7:0]       miss_cnt,
    output logic             overflow
);

    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_WAIT_REF = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          ref_sync_q, sig_sync_q;
    logic                ref_prev_q, sig_prev_q;
    logic [CNT_W-1:0]    phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]    phase_smp_q, phase_smp_d;
    logic [ACC_W-1:0]    phase_acc_q, phase_acc_d;
    logic [ACC_W-1:0]    period_acc_q, period_acc_d;
    logic [AVG_LOG2-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0]    phase_avg_q, phase_avg_d;
    logic [CNT_W-1:0]    period_avg_q, period_avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic [7:0]          miss_cnt_q, miss_cnt_d;
    logic                overflow_q, overflow_d;

    logic                ref_edge_c, sig_edge_c;
    logic                commit_c;
    logic [CNT_W-1:0]    commit_phase_c;
    logic [CNT_W-1:0]    period_smp_c;
    logic                period_sat_c;
    logic [ACC_W-1:0]    phase_sum_c, period_sum_c;

    // Identical 2-FF synchroniser plus previous-value stage on both channels; untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_sync_q <= '0;
            sig_sync_q <= '0;
            ref_prev_q <= 1'b0;
            sig_prev_q <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[0], ref_in};
            sig_sync_q <= {sig_sync_q[0], sig_in};
            ref_prev_q <= ref_sync_q[1];
            sig_prev_q <= sig_sync_q[1];
        end
    end

    assign ref_edge_c = ref_sync_q[1] & ~ref_prev_q;
    assign sig_edge_c = sig_sync_q[1] & ~sig_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            phase_cnt_q  <= '0;
            period_cnt_q <= '0;
            phase_smp_q  <= '0;
            phase_acc_q  <= '0;
            period_acc_q <= '0;
            smp_cnt_q    <= '0;
            phase_avg_q  <= '0;
            period_avg_q <= '0;
            avg_valid_q  <= 1'b0;
            miss_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            period_cnt_q <= period_cnt_d;
            phase_smp_q  <= phase_smp_d;
            phase_acc_q  <= phase_acc_d;
            period_acc_q <= period_acc_d;
            smp_cnt_q    <= smp_cnt_d;
            phase_avg_q  <= phase_avg_d;
            period_avg_q <= period_avg_d;
            avg_valid_q  <= avg_valid_d;
            miss_cnt_q   <= miss_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_cnt_d    = phase_cnt_q;
        period_cnt_d   = period_cnt_q;
        phase_smp_d    = phase_smp_q;
        phase_acc_d    = phase_acc_q;
        period_acc_d   = period_acc_q;
        smp_cnt_d      = smp_cnt_q;
        phase_avg_d    = phase_avg_q;
        period_avg_d   = period_avg_q;
        avg_valid_d    = 1'b0;
        miss_cnt_d     = miss_cnt_q;
        overflow_d     = overflow_q;
        commit_c       = 1'b0;
        commit_phase_c = '0;
        period_smp_c   = period_cnt_q + CNT_W'(1);
        period_sat_c   = (period_smp_c == CNT_MAX);

        case (state_q)
            S_IDLE: begin
                if (ref_edge_c) begin
                    phase_cnt_d  = '0;
                    period_cnt_d = '0;
                    if (sig_edge_c) begin
                        phase_smp_d = '0;
                        state_d     = S_WAIT_REF;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (ref_edge_c) begin
                    // Period closed without a sig edge: count a miss and restart.
                    miss_cnt_d   = (miss_cnt_q == 8'hFF) ? miss_cnt_q : miss_cnt_q + 8'd1;
                    phase_cnt_d  = '0;
                    period_cnt_d = '0;
                    if (sig_edge_c) begin
                        phase_smp_d = '0;
                        state_d     = S_WAIT_REF;
                    end
                end else begin
                    phase_cnt_d  = phase_cnt_q + CNT_W'(1);
                    period_cnt_d = period_smp_c;
                    if (period_sat_c) begin
                        overflow_d = 1'b1;
                        state_d    = S_IDLE;
                    end else if (sig_edge_c) begin
                        phase_smp_d = phase_cnt_q + CNT_W'(1);
                        state_d     = S_WAIT_REF;
                    end
                end
            end
            S_WAIT_REF: begin
                if (ref_edge_c) begin
                    commit_c       = 1'b1;
                    commit_phase_c = phase_smp_q;
                    phase_cnt_d    = '0;
                    period_cnt_d   = '0;
                    if (sig_edge_c) begin
                        phase_smp_d = '0;
                        state_d     = S_WAIT_REF;
                    end else begin
                        state_d = S_ARMED;
                    end
                end else begin
                    period_cnt_d = period_smp_c;
                    if (period_sat_c) begin
                        overflow_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        phase_sum_c  = phase_acc_q + ACC_W'(commit_phase_c);
        period_sum_c = period_acc_q + ACC_W'(period_smp_c);

        // Accumulate a complete pair; the final sample of a block is part of its average.
        if (commit_c) begin
            if (&smp_cnt_q) begin
                phase_avg_d  = CNT_W'(phase_sum_c >> AVG_LOG2);
                period_avg_d = CNT_W'(period_sum_c >> AVG_LOG2);
                avg_valid_d  = 1'b1;
                phase_acc_d  = '0;
                period_acc_d = '0;
                smp_cnt_d    = '0;
            end else begin
                phase_acc_d  = phase_sum_c;
                period_acc_d = period_sum_c;
                smp_cnt_d    = smp_cnt_q + AVG_LOG2'(1);
            end
        end

        if (clr) begin
            state_d      = S_IDLE;
            phase_cnt_d  = '0;
            period_cnt_d = '0;
            phase_smp_d  = '0;
            phase_acc_d  = '0;
            period_acc_d = '0;
            smp_cnt_d    = '0;
            phase_avg_d  = '0;
            period_avg_d = '0;
            avg_valid_d  = 1'b0;
            miss_cnt_d   = '0;
            overflow_d   = 1'b0;
        end
    end

    assign phase_avg  = phase_avg_q;
    assign period_avg = period_avg_q;
    assign avg_valid  = avg_valid_q;
    assign miss_cnt   = miss_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tdc_phase_meter.sv
// Directed bench: 16-bit meter for averaging tests, 12-bit meter sharing the pins for overflow.
module tb_tdc_phase_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        ref_in = 1'b0;
    logic        sig_in = 1'b0;

    logic [15:0] phase_avg, period_avg;
    logic        avg_valid, overflow;
    logic [7:0]  miss_cnt;
    logic [11:0] phase_avg2, period_avg2;
    logic        avg_valid2, overflow2;
    logic [7:0]  miss_cnt2;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int valid_cnt2 = 0;
    int snap = 0;
    int snap2 = 0;

    always #10 clk = ~clk;

    tdc_phase_meter #(.CNT_W(16), .AVG_LOG2(2)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ref_in(ref_in), .sig_in(sig_in),
        .phase_avg(phase_avg), .period_avg(period_avg), .avg_valid(avg_valid),
        .miss_cnt(miss_cnt), .overflow(overflow)
    );

    tdc_phase_meter #(.CNT_W(12), .AVG_LOG2(2)) u_ovf (
        .clk(clk), .rst(rst), .clr(clr), .ref_in(ref_in), .sig_in(sig_in),
        .phase_avg(phase_avg2), .period_avg(period_avg2), .avg_valid(avg_valid2),
        .miss_cnt(miss_cnt2), .overflow(overflow2)
    );

    always @(negedge clk) begin
        if (avg_valid)  valid_cnt  = valid_cnt + 1;
        if (avg_valid2) valid_cnt2 = valid_cnt2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n ref periods of p cycles (50% duty); sig is ref delayed by d0+i*dstep from period sig_from on.
    task automatic run_periods(input int n, input int p, input int d0, input int dstep,
                               input int sig_from);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                ref_in = (c < p / 2);
                sig_in = (i >= sig_from) && (c >= d0 + i * dstep) && (c < d0 + i * dstep + p / 2);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ref_in = 1'b0;
            sig_in = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        idle(4);
        chk("rst_phase", 32'(phase_avg), 0);
        chk("rst_period", 32'(period_avg), 0);
        chk("rst_valid", 32'(avg_valid), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        idle(5);

        // Constant delay 50 in period 200: one average after the 5th ref edge
        snap = valid_cnt;
        run_periods(5, 200, 50, 0, 0);
        idle(5);
        chk("t1_valid_once", 32'(valid_cnt - snap), 1);
        chk("t1_phase", 32'(phase_avg), 50);
        chk("t1_period", 32'(period_avg), 200);
        chk("t1_miss", 32'(miss_cnt), 0);

        // clr zeroes all outputs
        pulse_clr();
        chk("clr_phase", 32'(phase_avg), 0);
        chk("clr_period", 32'(period_avg), 0);
        chk("clr_valid", 32'(avg_valid), 0);
        chk("clr_ovf", 32'(overflow), 0);

        // Delays 100..103 in period 400: 406>>2 = 101
        snap = valid_cnt;
        run_periods(5, 400, 100, 1, 0);
        idle(5);
        chk("t2_valid_once", 32'(valid_cnt - snap), 1);
        chk("t2_phase_trunc", 32'(phase_avg), 101);
        chk("t2_period", 32'(period_avg), 400);

        // Zero delay: coincident edges
        pulse_clr();
        snap = valid_cnt;
        run_periods(5, 200, 0, 0, 0);
        idle(5);
        chk("t3_valid_once", 32'(valid_cnt - snap), 1);
        chk("t3_phase_zero", 32'(phase_avg), 0);
        chk("t3_period", 32'(period_avg), 200);
        chk("t3_miss", 32'(miss_cnt), 0);

        // sig absent for 3 periods: 3 misses, average needs 4 good pairs (8th ref edge)
        pulse_clr();
        snap = valid_cnt;
        run_periods(7, 200, 50, 0, 3);
        chk("t4_no_valid_yet", 32'(valid_cnt - snap), 0);
        chk("t4_miss", 32'(miss_cnt), 3);
        run_periods(1, 200, 50, 0, 0);
        chk("t4_valid_after_4", 32'(valid_cnt - snap), 1);
        chk("t4_phase", 32'(phase_avg), 50);
        chk("t4_period", 32'(period_avg), 200);

        // Partial accumulation with different timing, then 1-clk reset
        run_periods(3, 300, 80, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_phase", 32'(phase_avg), 0);
        chk("t5_rst_period", 32'(period_avg), 0);
        chk("t5_rst_miss", 32'(miss_cnt), 0);
        chk("t5_rst_valid", 32'(avg_valid), 0);
        chk("t5_rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        idle(5);
        snap = valid_cnt;
        run_periods(5, 200, 50, 0, 0);
        idle(5);
        chk("t5_valid_once", 32'(valid_cnt - snap), 1);
        chk("t5_phase_post", 32'(phase_avg), 50);
        chk("t5_period_post", 32'(period_avg), 200);
        chk("t5_miss", 32'(miss_cnt), 0);

        // 12-bit meter, ref period 5000: saturates at 4095 cycles after the ref edge
        pulse_clr();
        snap2 = valid_cnt2;
        for (int c = 0; c < 4400; c++) begin
            @(negedge clk);
            ref_in = (c < 2500);
            sig_in = 1'b0;
            if (c == 4000) chk("t6_ovf_not_yet", 32'(overflow2), 0);
        end
        chk("t6_ovf_set", 32'(overflow2), 1);
        chk("t6_wide_no_ovf", 32'(overflow), 0);
        idle(700);
        chk("t6_ovf_sticky", 32'(overflow2), 1);
        chk("t6_no_valid", 32'(valid_cnt2 - snap2), 0);
        pulse_clr();
        chk("t6_clr_ovf", 32'(overflow2), 0);

        // After clr the 12-bit meter measures normally again
        snap2 = valid_cnt2;
        run_periods(5, 200, 30, 0, 0);
        idle(5);
        chk("t6_post_clr_valid", 32'(valid_cnt2 - snap2), 1);
        chk("t6_post_clr_phase", 32'(phase_avg2), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
